uart_rx: RTL and testbench
==========================

# uart_rx

Serial receiver that consumes the single-wire `tx` stream produced by `uart_tx` and recovers 8-bit bytes. Input is 8N1: one start bit (0), eight data bits LSB first, one stop bit (1), at a fixed number of clocks per bit. The block synchronizes the asynchronous line, detects the start edge and samples each bit at mid-period. It presents each byte with a sticky `rdy` flag for the downstream consumer.

## Interface
- `BAUD_CNT`, default 12'hA2D (2605): clocks per bit period; 12-bit value, must be ≥ 4.
- `clk`  input  1  system clock, all logic on rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `rx`  input  1  serial line, asynchronous to `clk`, idles high.
- `clr_rdy`  input  1  consumer acknowledge; clears `rdy`.
- `rx_data`  output  8  last correctly received byte.
- `rdy`  output  1  byte available in `rx_data`.
- `frm_err`  output  1  stop bit sampled low on the last frame.

## Operation
- Reset values:
  - `rx_data` = 8'h00, `rdy` = 0, `frm_err` = 0, state = IDLE.
  - Both synchronizer flops are preset to 1.
  - Baud counter = 0, bit counter = 0.
- `rx` passes through a 2-flop synchronizer; a third flop holds the previous synchronized value for falling-edge detection.
- States: IDLE, RECEIVE.
- IDLE:
  - On a synchronized falling edge: go to RECEIVE, load baud counter with `BAUD_CNT>>1` and clear bit counter.
  - `rdy` is cleared on this cycle.
- RECEIVE:
  - The baud counter decrements every cycle.
  - When it reaches 0: sample the synchronized line into a 10-bit shift register (shifted in from the MSB), increment the bit counter and reload `BAUD_CNT`.
- Start-bit check: if the first sample (bit 0) is 1, the start was a glitch. Return to IDLE and leave `rdy`, `rx_data` and `frm_err` unchanged.
- On the 10th sample (stop bit), return to IDLE:
  - Stop = 1: `rx_data` ← data bits, `rdy` ← 1, `frm_err` ← 0.
  - Stop = 0: see Configuration.
- `rdy` is cleared by `clr_rdy`=1 or by the next start detection. Overrun is not flagged; an unconsumed byte is overwritten.
- Simultaneous set and `clr_rdy` on the same cycle: set wins, so `rdy`=1.
- Reset asserted mid-frame: everything returns to reset values immediately. A frame in progress is discarded, with no partial `rx_data` update.
- In IDLE the line being held low does not retrigger; a new frame needs a new falling edge.

## Timing
- Edge at the `rx` pin to start detection: 2–3 clk (synchronizer plus edge flop).
- Samples are taken at detect + `BAUD_CNT>>1`, then every `BAUD_CNT` clocks after that.
- Stop sample: detect + (`BAUD_CNT>>1`) + 9·`BAUD_CNT`.
- `rdy` rises on the clock following the stop sample.
- For default `BAUD_CNT`, `rdy` rises 1302 + 23445 + 1 = 24748 clk after detect, ±1.
- A following start edge is detected at earliest half a bit after the stop sample, so back-to-back frames with no idle gap are received.
- `rx_data` is stable whenever `rdy`=1 until the next stop sample.

## Configuration
- Macro `UART_RX_FRAMING_CHECK_EN`.
- Defined: a stop sample of 0 sets `frm_err`=1 and leaves `rdy` = 0 and `rx_data` unchanged. `frm_err` clears on the next valid frame or on reset.
- Undefined:
  - The stop bit is ignored; every frame that passes the start-bit check loads `rx_data` and sets `rdy`.
  - `frm_err` is tied to 0.

## Test plan
- Loopback from `uart_tx` with default `BAUD_CNT`, sending 8'hA5:
  - `rx_data`=8'hA5 and `rdy`=1 within 24748±3 clk of start detect.
  - `frm_err`=0.
- Back-to-back 8'h00 then 8'hFF with no idle gap, pulsing `clr_rdy` after each byte:
  - Two `rdy` rises with `rx_data` 8'h00 then 8'hFF.
  - `rdy`=0 during the second frame.
- Glitch: drive `rx` low for 100 clk, then high.
  - No `rdy`, `rx_data` unchanged, back in IDLE.
  - A following 8'h3C is still received correctly.
- Framing error: bench drives 8'h3C with stop = 0.
  - With macro: `frm_err`=1, `rdy`=0, `rx_data` keeps its previous value.
  - Without macro: `rdy`=1, `rx_data`=8'h3C.
- `clr_rdy` asserted on the same cycle `rdy` would set: `rdy`=1. Asserted one cycle later: `rdy`=0 next clock.
- `rst_n` pulsed low mid-frame after bit 4:
  - Outputs return to reset values immediately.
  - The remainder of the frame produces no `rdy`.
  - The next full frame of 8'h81 gives `rx_data`=8'h81.

Source files
------------

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line, consumer acknowledge and received-byte status.
// master = line driver / byte consumer, slave = receiver.
interface uart_rx_if;
  logic       rx;
  logic       clr_rdy;
  logic [7:0] rx_data;
  logic       rdy;
  logic       frm_err;

  modport master (
    output rx, clr_rdy,
    input  rx_data, rdy, frm_err
  );

  modport slave (
    input  rx, clr_rdy,
    output rx_data, rdy, frm_err
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with mid-bit sampling and sticky rdy flag.
// Optional stop-bit checking: define UART_RX_FRAMING_CHECK_EN.
module uart_rx #(
  parameter logic [11:0] BAUD_CNT = 12'hA2D
) (
  input logic      clk,
  input logic      rst_n,
  uart_rx_if.slave bus
);

  typedef enum logic {IDLE, RECEIVE} state_t;

  localparam logic [11:0] HALF = BAUD_CNT >> 1;
  localparam logic [11:0] RELOAD = BAUD_CNT - 12'd1;

  state_t      state, state_nx;
  logic        sync1, sync2, prev;
  logic [11:0] baud_cnt;
  logic [3:0]  bit_cnt;
  logic [9:0]  shreg;
  logic        fall, tick;
  logic        start, done, load;
  logic        unused_bits;

  assign fall = prev & ~sync2;
  assign tick = (baud_cnt == 12'd0);
  assign unused_bits = ^shreg[1:0];

  // line synchronizer and edge-detect history, idle-high at reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= bus.rx;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // next state and frame strobes
  always_comb begin
    state_nx = state;
    start    = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (fall) begin
          start    = 1'b1;
          state_nx = RECEIVE;
        end
      end
      RECEIVE: begin
        if (tick) begin
          if (bit_cnt == 4'd0 && sync2) begin
            state_nx = IDLE;
          end else if (bit_cnt == 4'd9) begin
            done     = 1'b1;
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // baud timing, bit counting and sample shifting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt <= 12'd0;
      bit_cnt  <= 4'd0;
      shreg    <= 10'd0;
    end else if (start) begin
      baud_cnt <= HALF;
      bit_cnt  <= 4'd0;
    end else if (state == RECEIVE) begin
      if (tick) begin
        baud_cnt <= RELOAD;
        bit_cnt  <= bit_cnt + 4'd1;
        shreg    <= {sync2, shreg[9:1]};
      end else begin
        baud_cnt <= baud_cnt - 12'd1;
      end
    end
  end

`ifdef UART_RX_FRAMING_CHECK_EN
  assign load = done & sync2;

  // framing error flag: set on a low stop bit, cleared by a good frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             bus.frm_err <= 1'b0;
    else if (load)          bus.frm_err <= 1'b0;
    else if (done & ~sync2) bus.frm_err <= 1'b1;
  end
`else
  assign load = done;
  assign bus.frm_err = 1'b0;
`endif

  // received byte and sticky ready; a new byte beats a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rx_data <= 8'h00;
      bus.rdy     <= 1'b0;
    end else begin
      if (load) bus.rx_data <= shreg[9:2];
      if (load)                      bus.rdy <= 1'b1;
      else if (bus.clr_rdy || start) bus.rdy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized frames plus directed corner cases,
// scoreboard queue checked by an independent rdy monitor.
module tb_uart_rx;

  localparam int BAUD = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_rx_if bus();

  uart_rx #(.BAUD_CNT(12'd16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];
  bit         auto_clr = 1'b1;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic bit_out(input logic b);
    bus.rx = b;
    repeat (BAUD) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input logic stp, input bit mid);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) begin
      bit_out(d[i]);
      if (mid && i == 3) check("rdy_low_mid_frame", bus.rdy, 0);
    end
    bit_out(stp);
    bus.rx = 1'b1;
  endtask

  task automatic frame(input logic [7:0] d, input bit mid);
    exp_q.push_back(d);
    send(d, 1'b1, mid);
  endtask

  // monitor: every rising rdy must match the oldest expected byte
  initial begin
    logic       last;
    logic [7:0] e;
    last = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.rdy && !last) begin
        check("rdy_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("rx_data", bus.rx_data, e);
        end
        if (auto_clr) begin
          bus.clr_rdy = 1'b1;
          @(negedge clk);
          bus.clr_rdy = 1'b0;
          check("clr_rdy_clears", bus.rdy, 0);
        end
      end
      last = bus.rdy;
    end
  end

  initial begin
    logic [7:0] d, d2, held;
    bit         found;

    bus.rx = 1'b1;
    bus.clr_rdy = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rx_data", bus.rx_data, 0);
    check("reset_rdy", bus.rdy, 0);
    check("reset_frm_err", bus.frm_err, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // random frames, gaps of 0..2 idle bits
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom);
      frame(d, 1'b0);
      repeat ($urandom_range(0, 2) * BAUD) @(negedge clk);
    end

    // back-to-back 00 then FF
    frame(8'h00, 1'b0);
    frame(8'hFF, 1'b1);
    repeat (2 * BAUD) @(negedge clk);

    // without consumer: rdy holds, next start clears it, byte overwritten
    auto_clr = 1'b0;
    d = 8'($urandom);
    frame(d, 1'b0);
    check("rdy_sticky", bus.rdy, 1);
    d2 = 8'($urandom);
    frame(d2, 1'b1);
    check("rdy_overwrite", bus.rdy, 1);
    check("rx_data_overwrite", bus.rx_data, {24'd0, d2});
    bus.clr_rdy = 1'b1;
    @(negedge clk);
    bus.clr_rdy = 1'b0;
    check("manual_clr", bus.rdy, 0);
    auto_clr = 1'b1;
    repeat (BAUD) @(negedge clk);

    // short low glitch is rejected
    held = bus.rx_data;
    bus.rx = 1'b0;
    repeat (4) @(negedge clk);
    bus.rx = 1'b1;
    repeat (3 * BAUD) @(negedge clk);
    check("glitch_no_rdy", bus.rdy, 0);
    check("glitch_data_kept", bus.rx_data, {24'd0, held});
    frame(8'h3C, 1'b0);
    repeat (BAUD) @(negedge clk);

    // framing error on stop bit
    frame(8'h5A, 1'b0);
    repeat (BAUD) @(negedge clk);
`ifdef UART_RX_FRAMING_CHECK_EN
    send(8'h3C, 1'b0, 1'b0);
    repeat (BAUD) @(negedge clk);
    check("ferr_set", bus.frm_err, 1);
    check("ferr_no_rdy", bus.rdy, 0);
    check("ferr_data_kept", bus.rx_data, 32'h5A);
`else
    exp_q.push_back(8'h3C);
    send(8'h3C, 1'b0, 1'b0);
    repeat (BAUD) @(negedge clk);
    check("ferr_off", bus.frm_err, 0);
    check("ferr_off_data", bus.rx_data, 32'h3C);
`endif
    frame(8'h96, 1'b0);
    repeat (BAUD) @(negedge clk);
    check("ferr_cleared", bus.frm_err, 0);

    // clear held across the set cycle: set wins, then clears
    auto_clr = 1'b0;
    bus.clr_rdy = 1'b1;
    exp_q.push_back(8'hC3);
    d = 8'hC3;
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(d[i]);
    bus.rx = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 2 * BAUD && !found; k++) begin
      @(negedge clk);
      if (bus.rdy) found = 1'b1;
    end
    check("set_wins_over_clr", found, 1);
    @(negedge clk);
    check("clr_next_clock", bus.rdy, 0);
    bus.clr_rdy = 1'b0;
    auto_clr = 1'b1;
    repeat (2 * BAUD) @(negedge clk);

    // reset in the middle of a frame
    d = 8'hE0 | 8'($urandom_range(0, 31));
    bit_out(1'b0);
    for (int i = 0; i < 5; i++) bit_out(d[i]);
    rst_n = 1'b0;
    #1;
    check("midrst_rx_data", bus.rx_data, 0);
    check("midrst_rdy", bus.rdy, 0);
    check("midrst_frm_err", bus.frm_err, 0);
    @(negedge clk);
    bus.rx = d[5];
    rst_n = 1'b1;
    for (int i = 5; i < 8; i++) bit_out(d[i]);
    bit_out(1'b1);
    repeat (2 * BAUD) @(negedge clk);
    check("midrst_no_rdy", bus.rdy, 0);
    check("midrst_no_data", bus.rx_data, 0);
    frame(8'h81, 1'b0);
    repeat (BAUD) @(negedge clk);
    check("after_rst_data", bus.rx_data, 32'h81);

    repeat (4 * BAUD) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
